// File: rtl/hoplite_inject_if.sv
// PE-side injection link: the router takes the queue head when pkt_out_ready is high.
interface hoplite_inject_if #(
  parameter int COORD_BITS = 1
);
  localparam int PKT_W = 2 * COORD_BITS + 32;

  logic [PKT_W-1:0] pkt_out;
  logic             pkt_out_valid;
  logic             pkt_out_ready;

  modport master (output pkt_out, output pkt_out_valid, input pkt_out_ready);
  modport slave  (input pkt_out, input pkt_out_valid, output pkt_out_ready);
endinterface

// File: rtl/hoplite_inject_ctrl.sv
// Builds {x, y, payload} packets from core strobes and queues them in a
// first-word-fall-through FIFO feeding the router's PE injection port.
module hoplite_inject_ctrl #(
  parameter int COORD_BITS   = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [31:0]                     message_in,
  input  logic                            message_in_valid,
  input  logic                            packet_complete,
  input  logic                            clear_status,
  hoplite_inject_if.master                pkt_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            fifo_full,
  output logic                            overflow_flag,
  output logic                            incomplete_flag,
  output logic                            starve_flag
);
  localparam int PKT_W = 2 * COORD_BITS + 32;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [COORD_BITS-1:0] x_held_q, x_held_d;
  logic [COORD_BITS-1:0] y_held_q, y_held_d;
  logic [31:0]           msg_reg_q, msg_reg_d;
  logic                  msg_held_q, msg_held_d;

  logic [PKT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  incomplete_q, incomplete_d;
  logic                  starve_q, starve_d;

  logic                  head_valid;
  logic                  full;
  logic                  pop;
  logic                  push_req;
  logic                  push;
  logic                  blocked;
  logic                  starve_set;
  logic [PKT_W-1:0]      pkt_in;

  // Same-cycle strobes bypass the held registers so the packet sees this cycle's values.
  always_comb begin
    pkt_in = {x_coord_in_valid ? x_coord_in : x_held_q,
              y_coord_in_valid ? y_coord_in : y_held_q,
              message_in_valid ? message_in : msg_reg_q};
  end

  assign head_valid = (count_q != '0);
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = head_valid && pkt_if.pkt_out_ready;
  assign push_req   = packet_complete && (msg_held_q || message_in_valid);
  assign push       = push_req && (!full || pop);
  assign blocked    = head_valid && !pkt_if.pkt_out_ready;
  assign starve_set = blocked && (starve_cnt_q == SC_W'(STARVE_LIMIT - 1));

  always_comb begin
    x_held_d   = x_coord_in_valid ? x_coord_in : x_held_q;
    y_held_d   = y_coord_in_valid ? y_coord_in : y_held_q;
    msg_reg_d  = message_in_valid ? message_in : msg_reg_q;
    msg_held_d = msg_held_q;
    if (packet_complete) begin
      msg_held_d = 1'b0;
    end else if (message_in_valid) begin
      msg_held_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Counter restarts whenever the head moves or the queue drains; it holds at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!blocked) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  // Sticky flags: a set event in the same cycle as clear_status wins.
  always_comb begin
    overflow_d   = (push_req && !push) ? 1'b1 : (clear_status ? 1'b0 : overflow_q);
    incomplete_d = (packet_complete && !push_req) ? 1'b1 :
                   (clear_status ? 1'b0 : incomplete_q);
    starve_d     = starve_set ? 1'b1 : (clear_status ? 1'b0 : starve_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_held_q     <= '0;
      y_held_q     <= '0;
      msg_reg_q    <= '0;
      msg_held_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      overflow_q   <= 1'b0;
      incomplete_q <= 1'b0;
      starve_q     <= 1'b0;
    end else begin
      x_held_q     <= x_held_d;
      y_held_q     <= y_held_d;
      msg_reg_q    <= msg_reg_d;
      msg_held_q   <= msg_held_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      overflow_q   <= overflow_d;
      incomplete_q <= incomplete_d;
      starve_q     <= starve_d;
    end
  end

  // Storage needs no reset: the head is masked until the count says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pkt_in;
    end
  end

  assign pkt_if.pkt_out       = head_valid ? mem_q[rd_ptr_q] : '0;
  assign pkt_if.pkt_out_valid = head_valid;
  assign fifo_count           = count_q;
  assign fifo_full            = full;
  assign overflow_flag        = overflow_q;
  assign incomplete_flag      = incomplete_q;
  assign starve_flag          = starve_q;
endmodule

// File: tb/tb_hoplite_inject_ctrl.sv
// Directed bench for hoplite_inject_ctrl: assembly, FIFO ordering, overflow, flags, starvation, reset.
module tb_hoplite_inject_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [0:0]  x_coord_in, y_coord_in;
  logic        x_coord_in_valid, y_coord_in_valid;
  logic [31:0] message_in;
  logic        message_in_valid, packet_complete, clear_status;
  logic [2:0]  fifo_count;
  logic        fifo_full, overflow_flag, incomplete_flag, starve_flag;

  int total = 0;
  int bad   = 0;

  hoplite_inject_if #(.COORD_BITS(1)) pkt_if ();

  hoplite_inject_ctrl #(.COORD_BITS(1), .FIFO_DEPTH(4), .STARVE_LIMIT(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .x_coord_in       (x_coord_in),
    .x_coord_in_valid (x_coord_in_valid),
    .y_coord_in       (y_coord_in),
    .y_coord_in_valid (y_coord_in_valid),
    .message_in       (message_in),
    .message_in_valid (message_in_valid),
    .packet_complete  (packet_complete),
    .clear_status     (clear_status),
    .pkt_if           (pkt_if.master),
    .fifo_count       (fifo_count),
    .fifo_full        (fifo_full),
    .overflow_flag    (overflow_flag),
    .incomplete_flag  (incomplete_flag),
    .starve_flag      (starve_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] mk(input logic x, input logic y, input logic [31:0] m);
    return {x, y, m};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one edge and settle; strobes are one-shot and drop afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    x_coord_in_valid = 1'b0;
    y_coord_in_valid = 1'b0;
    message_in_valid = 1'b0;
    packet_complete  = 1'b0;
    clear_status     = 1'b0;
  endtask

  task automatic send(input logic [31:0] m);
    message_in       = m;
    message_in_valid = 1'b1;
    packet_complete  = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    x_coord_in = '0; y_coord_in = '0; message_in = '0;
    x_coord_in_valid = 0; y_coord_in_valid = 0; message_in_valid = 0;
    packet_complete = 0; clear_status = 0;
    pkt_if.pkt_out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    chk("rst_valid",  64'(pkt_if.pkt_out_valid), 64'd0);
    chk("rst_pkt",    64'(pkt_if.pkt_out), 64'd0);
    chk("rst_count",  64'(fifo_count), 64'd0);
    chk("rst_flags",  64'({fifo_full, overflow_flag, incomplete_flag, starve_flag}), 64'd0);

    // Single packet, router ready
    pkt_if.pkt_out_ready = 1'b1;
    x_coord_in = 1'b1; x_coord_in_valid = 1'b1;
    y_coord_in = 1'b0; y_coord_in_valid = 1'b1;
    message_in = 32'hDEADBEEF; message_in_valid = 1'b1;
    tick();
    chk("held_no_push", 64'(pkt_if.pkt_out_valid), 64'd0);
    packet_complete = 1'b1;
    tick();
    chk("p1_valid", 64'(pkt_if.pkt_out_valid), 64'd1);
    chk("p1_pkt",   64'(pkt_if.pkt_out), 64'(mk(1'b1, 1'b0, 32'hDEADBEEF)));
    chk("p1_count", 64'(fifo_count), 64'd1);
    tick();
    chk("p1_gone",  64'(pkt_if.pkt_out_valid), 64'd0);
    chk("p1_cnt0",  64'(fifo_count), 64'd0);

    // Fill four, overflow on the fifth, then drain in order
    pkt_if.pkt_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(32'(i));
      chk("fill_count", 64'(fifo_count), 64'(i));
    end
    chk("full",      64'(fifo_full), 64'd1);
    chk("ovf_before", 64'(overflow_flag), 64'd0);
    send(32'd5);
    chk("ovf_set",   64'(overflow_flag), 64'd1);
    chk("ovf_count", 64'(fifo_count), 64'd4);
    chk("head1",     64'(pkt_if.pkt_out), 64'(mk(1'b1, 1'b0, 32'd1)));
    pkt_if.pkt_out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("drain_head", 64'(pkt_if.pkt_out), 64'(mk(1'b1, 1'b0, 32'(i))));
      chk("drain_count", 64'(fifo_count), 64'(5 - i));
    end
    tick();
    chk("drain_empty", 64'(pkt_if.pkt_out_valid), 64'd0);
    clear_status = 1'b1;
    tick();
    chk("ovf_clear", 64'(overflow_flag), 64'd0);

    // Full queue with simultaneous pop and push
    pkt_if.pkt_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i));
    pkt_if.pkt_out_ready = 1'b1;
    send(32'hA4);
    chk("pp_count", 64'(fifo_count), 64'd4);
    chk("pp_ovf",   64'(overflow_flag), 64'd0);
    chk("pp_head",  64'(pkt_if.pkt_out), 64'(mk(1'b1, 1'b0, 32'hA1)));
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("pp_drain", 64'(pkt_if.pkt_out), 64'(mk(1'b1, 1'b0, 32'hA0 + 32'(i))));
    end
    tick();
    chk("pp_empty", 64'(fifo_count), 64'd0);

    // Complete with no payload
    packet_complete = 1'b1;
    tick();
    chk("inc_set",   64'(incomplete_flag), 64'd1);
    chk("inc_nopkt", 64'(pkt_if.pkt_out_valid), 64'd0);
    clear_status = 1'b1;
    tick();
    chk("inc_clear", 64'(incomplete_flag), 64'd0);
    packet_complete = 1'b1;
    clear_status    = 1'b1;
    tick();
    chk("inc_set_wins", 64'(incomplete_flag), 64'd1);
    clear_status = 1'b1;
    tick();

    // Starvation: 64 blocked cycles, payload and coordinates written in separate cycles
    pkt_if.pkt_out_ready = 1'b0;
    message_in = 32'h1234_5678; message_in_valid = 1'b1;
    tick();
    x_coord_in = 1'b0; x_coord_in_valid = 1'b1;
    y_coord_in = 1'b1; y_coord_in_valid = 1'b1;
    tick();
    packet_complete = 1'b1;
    tick();
    chk("sep_pkt", 64'(pkt_if.pkt_out), 64'(mk(1'b0, 1'b1, 32'h1234_5678)));
    for (int i = 0; i < 63; i++) tick();
    chk("starve_63", 64'(starve_flag), 64'd0);
    tick();
    chk("starve_64", 64'(starve_flag), 64'd1);
    pkt_if.pkt_out_ready = 1'b1;
    tick();
    chk("starve_sticky", 64'(starve_flag), 64'd1);
    clear_status = 1'b1;
    tick();
    chk("starve_clear", 64'(starve_flag), 64'd0);

    // Ready arrives on the 64th cycle: no starvation
    pkt_if.pkt_out_ready = 1'b0;
    send(32'h77);
    for (int i = 0; i < 63; i++) tick();
    pkt_if.pkt_out_ready = 1'b1;
    tick();
    chk("nostarve_pop",  64'(pkt_if.pkt_out_valid), 64'd0);
    chk("nostarve_flag", 64'(starve_flag), 64'd0);

    // Reset with three packets queued and a flag raised
    pkt_if.pkt_out_ready = 1'b0;
    send(32'h1); send(32'h2); send(32'h3);
    packet_complete = 1'b1;
    tick();
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    chk("pre_rst_inc",   64'(incomplete_flag), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(pkt_if.pkt_out_valid), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_flags", 64'({fifo_full, overflow_flag, incomplete_flag, starve_flag}), 64'd0);
    packet_complete = 1'b1;
    tick();
    chk("rst_msg_held", 64'(pkt_if.pkt_out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
